// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants and state type for the 8-to-3 priority encoder
package encoder_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

endpackage

// File: rtl/prio_pick_8to3.sv
// rtl/prio_pick_8to3.sv - combinational vector-to-index priority pick
//
// Ports:
//   vec   in  [N_LINES-1:0]  candidate lines
//   code  out [CODE_W-1:0]   index of the winning line (0 when found=0)
//   found out                vec has at least one bit set
// HIGH_FIRST=1 picks the highest set index, 0 the lowest.
module prio_pick_8to3
    import encoder_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [N_LINES-1:0] vec,
    output logic [CODE_W-1:0]  code,
    output logic               found
);

    // The loop direction makes the last assignment the winner.
    always_comb begin
        code  = '0;
        found = |vec;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N_LINES; i++) begin
                if (vec[i]) begin
                    code = CODE_W'(i);
                end
            end
        end else begin
            for (int i = N_LINES - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    code = CODE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/priority_encoder_8to3.sv
// rtl/priority_encoder_8to3.sv - sticky-pending 8-to-3 priority encoder with valid/ready drain
//
// Ports:
//   clk      in            rising-edge clock
//   rst_n    in            asynchronous active-low reset
//   a        in  [7:0]     request lines, a high bit at an edge is an event
//   enable   in            0 = ignore a (pending events still drain)
//   flush    in            synchronous clear of pending events and output
//   y        out [2:0]     encoded line index, held while valid && !ready
//   valid    out           y holds a code
//   ready    in            consumer accepts y on valid && ready
//   pending  out [7:0]     events waiting, excluding the code in y
//   overrun  out           one-cycle pulse: event merged into an already-pending line
module priority_encoder_8to3
    import encoder_pkg::*;
#(
    parameter bit PRIO_HIGH_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] a,
    input  logic               enable,
    input  logic               flush,
    output logic [CODE_W-1:0]  y,
    output logic               valid,
    input  logic               ready,
    output logic [N_LINES-1:0] pending,
    output logic               overrun
);

    enc_state_t         state_q, state_d;
    logic [CODE_W-1:0]  y_q, y_d;
    logic               valid_q, valid_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic               overrun_q, overrun_d;

    logic [CODE_W-1:0]  pick_code;
    logic               pick_found;
    logic [N_LINES-1:0] cap;
    logic [N_LINES-1:0] served;
    logic               accept;
    logic               load;

    prio_pick_8to3 #(
        .HIGH_FIRST (PRIO_HIGH_FIRST)
    ) u_pick (
        .vec   (pending_q),
        .code  (pick_code),
        .found (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        overrun_d = 1'b0;

        // Flush discards this cycle's capture as well as everything pending.
        cap    = flush ? '0 : (a & {N_LINES{enable}});
        accept = valid_q && ready;
        // A new code loads when the output slot is free now or is freed this edge.
        load   = !flush && pick_found && ((state_q == IDLE) || accept);
        served = load ? (N_LINES'(1) << pick_code) : '0;

        if (flush) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            y_d       = '0;
            pending_d = '0;
        end else begin
            // Capture is OR-ed after the clear, so a bit served and
            // re-requested at the same edge stays pending.
            pending_d = (pending_q & ~served) | cap;
            overrun_d = |(cap & pending_q & ~served);
            case (state_q)
                IDLE: begin
                    if (load) begin
                        y_d     = pick_code;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        if (load) begin
                            y_d = pick_code;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign y       = y_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb/tb_priority_encoder_8to3.sv - self-checking bench for priority_encoder_8to3
module tb_priority_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a;
    logic       enable;
    logic       flush;
    logic       ready;

    logic [2:0] y_hi, y_lo;
    logic       valid_hi, valid_lo;
    logic [7:0] pending_hi, pending_lo;
    logic       overrun_hi, overrun_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    priority_encoder_8to3 #(.PRIO_HIGH_FIRST(1'b1)) dut_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .enable  (enable),
        .flush   (flush),
        .y       (y_hi),
        .valid   (valid_hi),
        .ready   (ready),
        .pending (pending_hi),
        .overrun (overrun_hi)
    );

    priority_encoder_8to3 #(.PRIO_HIGH_FIRST(1'b0)) dut_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .enable  (enable),
        .flush   (flush),
        .y       (y_lo),
        .valid   (valid_lo),
        .ready   (ready),
        .pending (pending_lo),
        .overrun (overrun_lo)
    );

    typedef struct {
        logic [7:0] a;
        logic       en;
        logic       fl;
        logic       rdy;
        logic [2:0] y;
        logic       valid;
        logic [7:0] pending;
        logic       overrun;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hi(input string tag, input logic [2:0] ey, input logic ev,
                          input logic [7:0] ep, input logic eo);
        chk({tag, ".y"}, {5'd0, y_hi}, {5'd0, ey});
        chk({tag, ".valid"}, {7'd0, valid_hi}, {7'd0, ev});
        chk({tag, ".pending"}, pending_hi, ep);
        chk({tag, ".overrun"}, {7'd0, overrun_hi}, {7'd0, eo});
    endtask

    initial begin
        //         a      en    fl    rdy   y     vld   pending  ovr
        // two events, drained high-first back to back
        tbl[0]  = '{8'h24, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h24, 1'b0};
        tbl[1]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 8'h04, 1'b0};
        tbl[2]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h00, 1'b0};
        tbl[3]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0};
        // hold y=3 with ready low, re-request line 3 while outstanding
        tbl[4]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 8'h08, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 1'b0};
        tbl[6]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[10] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00, 1'b0};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0};
        // overrun on pending line 4 while y=0 is outstanding
        tbl[12] = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 8'h01, 1'b0};
        tbl[13] = '{8'h10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h10, 1'b0};
        tbl[14] = '{8'h10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h10, 1'b1};
        tbl[15] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h10, 1'b0};
        tbl[16] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 8'h00, 1'b0};
        tbl[17] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0};
        // enable low ignores a, then flush drops pending and output
        tbl[18] = '{8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0};
        tbl[19] = '{8'hC0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 8'hC0, 1'b0};
        tbl[20] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 8'h40, 1'b0};
        tbl[21] = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[22] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        // served and captured at the same edge: capture wins, two codes
        tbl[23] = '{8'h20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 1'b0};
        tbl[24] = '{8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 8'h20, 1'b0};
        tbl[25] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 8'h00, 1'b0};
        tbl[26] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0};

        rst_n  = 1'b0;
        a      = 8'h00;
        enable = 1'b1;
        flush  = 1'b0;
        ready  = 1'b1;
        step();
        step();
        chk_hi("reset", 3'd0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            a      = tbl[i].a;
            enable = tbl[i].en;
            flush  = tbl[i].fl;
            ready  = tbl[i].rdy;
            step();
            chk_hi($sformatf("vec%0d", i), tbl[i].y, tbl[i].valid, tbl[i].pending, tbl[i].overrun);
        end

        // Low-first instance: lines 0 and 7 drain as 0 then 7; high-first does 7 then 0.
        a = 8'h81; enable = 1'b1; flush = 1'b0; ready = 1'b1;
        step();
        chk("lo.pending", pending_lo, 8'h81);
        a = 8'h00;
        step();
        chk("lo.first", {5'd0, y_lo}, 8'd0);
        chk("lo.first_valid", {7'd0, valid_lo}, 8'd1);
        chk("hi.first", {5'd0, y_hi}, 8'd7);
        step();
        chk("lo.second", {5'd0, y_lo}, 8'd7);
        chk("hi.second", {5'd0, y_hi}, 8'd0);
        step();
        chk("lo.drained", {7'd0, valid_lo}, 8'd0);

        // Reset asserted mid-drain clears outputs without waiting for an edge.
        a = 8'h8F; ready = 1'b0;
        step();
        a = 8'h00;
        step();
        chk_hi("pre_rst", 3'd7, 1'b1, 8'h0F, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_hi("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_hi($sformatf("post_rst%0d", i), 3'd0, 1'b0, 8'h00, 1'b0);
        end
        a = 8'h02;
        step();
        a = 8'h00;
        step();
        chk_hi("post_rst_req", 3'd1, 1'b1, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_encoder_8to3.md
# priority_encoder_8to3

Sequential 8-to-3 priority encoder: the return path for the 3-to-8 decoder. It captures event pulses on eight request lines into a sticky pending register. It then drains them one at a time as 3-bit codes over a valid/ready handshake, serving the highest-priority pending line first. It sits between event sources and any consumer that takes a binary line index, such as a decoder driving acknowledges.

## Interface
- `PRIO_HIGH_FIRST`, default 1: 1 = line 7 has the highest priority; 0 = line 0 has the highest priority.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `a` input 8: request lines; any bit high at an edge is an event.
- `enable` input 1: 0 = `a` is ignored (no capture); pending events are kept and still drain.
- `flush` input 1: synchronous clear of pending events and of the output.
- `y` output 3: encoded line index; stable while `valid`=1 and `ready`=0.
- `valid` output 1: `y` holds a code.
- `ready` input 1: consumer accepts `y` when `valid`=1 and `ready`=1 at an edge.
- `pending` output 8: registered pending-event vector (excludes the code currently in `y`).
- `overrun` output 1: one-cycle pulse; an event was merged into an already-pending line.

## Operation
- Capture term: `cap = a & {8{enable}}`.
- State machine has two states:
  - IDLE: `valid`=0. If `pending`≠0, load `y` = pick(`pending`), clear that bit, set `valid`=1, and go to HOLD.
  - HOLD: `valid`=1. On accept, if `pending`≠0 (value before this edge), load the next pick, clear its bit, and stay in HOLD (back-to-back, one code per cycle). Otherwise go to IDLE with `valid`=0. Without accept, hold `y`, `valid` and state.
- pick(): the highest set index if `PRIO_HIGH_FIRST`=1, otherwise the lowest set index. It is evaluated only when `pending`≠0.
- Pending update: `pending_next = (pending & ~served_onehot) | cap`.
  - `served_onehot` is the one-hot of the code loaded this edge, or 0 if none is loaded.
  - When a bit is both served and captured at the same edge, capture wins: the bit stays pending and produces a second code later.
- A capture on line i while `y`==i is outstanding becomes pending normally and is not an overrun.
- `overrun` is set for one cycle after any edge where `cap[i]`=1, `pending[i]`=1 and i is not being served that edge.
- `flush`=1 at an edge:
  - `pending`←0, `valid`←0, state←IDLE, `overrun`←0.
  - `cap` is discarded that cycle.
  - An accept in the same cycle completes from the consumer's view, but nothing new loads.
- Reset (asynchronous, active-low): `pending`=0, `y`=3'b000, `valid`=0, `overrun`=0, state IDLE. No output glitches away from these values while `rst_n`=0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency from a request at edge k: `pending` set after edge k; `valid`/`y` after edge k+1 if the output was idle.
- Sustained throughput: 1 code/cycle while `ready`=1 and `pending`≠0.
- `y` must not change while `valid`=1 and `ready`=0 (AXI-style hold rule). `valid` never drops without an accept, except on flush or reset.
- Reset deassertion is synchronised externally; the first active edge after release behaves as a normal IDLE cycle.

## Structure
- Package `encoder_pkg` holds:
  - `localparam N_LINES = 8` and `CODE_W = 3`.
  - `typedef enum logic {IDLE, HOLD} enc_state_t`.
- Sub-module `prio_pick_8to3`: purely combinational. Inputs are the vector and the direction parameter; outputs are `code[2:0]` and `found`. It is reused wherever a vector-to-index pick is needed.
- The top level holds the FSM, the pending register and the overrun logic only.

## Test plan
- Reset, then `a`=8'b0010_0100 for one cycle with `ready`=1 → `y`=5 then `y`=2 on consecutive cycles, then `valid`=0; `pending` ends at 0.
- `PRIO_HIGH_FIRST`=0, `a`=8'b1000_0001 → `y`=0 first, then `y`=7.
- `ready`=0 for 5 cycles with `y`=3 valid → `y` and `valid` stable for all 5. Meanwhile `a`=8'b0000_1000 pulses → `pending`=8'b0000_1000, `overrun`=0. After `ready`=1, `y`=3 appears again.
- `pending[4]`=1 (not being served) and `a[4]` pulsed → `overrun`=1 for exactly one cycle; only one code 4 is later emitted.
- `enable`=0 with `a`=8'hFF → `pending` unchanged and `valid` stays 0. Then `flush`=1 with pending events → `pending`=0 and `valid`=0 next cycle.
- `rst_n` asserted mid-drain (`valid`=1, `pending`=8'h0F) → all outputs immediately 0, and nothing is emitted after release until a new request arrives.
